ps2_kbd_in: RTL
===============

// Module: ps2_kbd_in
// PURPOSE
//  CPU-readable PS/2 keyboard receiver: the input-direction counterpart of the
//  CPU output port. Deserialises PS/2 device-to-host frames into a byte FIFO
//  and exposes DATA/STATUS registers on the 65C02 bus with a level IRQ.
//  Runs on the system (dot) clock; the CPU read strobe is presented in that domain.
// PARAMETERS
//  BASE_ADDR       16'hFE10  DATA at BASE_ADDR, STATUS at BASE_ADDR+1
//  FIFO_AW         3         FIFO depth = 2**FIFO_AW entries (8)
//  TIMEOUT_CYCLES  25000     clk cycles with no PS/2 clock fall before a partial frame aborts
// PORTS
//  clk       in   1   system clock; all state on posedge
//  reset_n   in   1   asynchronous, active-low reset
//  ps2_clk   in   1   raw PS/2 clock line (asynchronous)
//  ps2_data  in   1   raw PS/2 data line (asynchronous)
//  addr      in   16  CPU address bus
//  rd_en     in   1   one-clk pulse: CPU read of addr completes (side effects fire here)
//  data_out  out  8   read data for addr (combinational from addr and state)
//  irq       out  1   high while FIFO non-empty
// BEHAVIOUR
//  Reset: FIFO empty, pointers 0, state IDLE, sticky flags 0; data_out=0, irq=0.
//  Sync: ps2_clk and ps2_data each pass through 2 flops; a fall = prev 1, now 0.
//   All bit sampling uses synchronised ps2_data on a detected fall.
//  FSM (advances only on a detected fall, except timeout):
//   IDLE   : data=0 -> DATA, bitcnt=0; data=1 -> stay (spurious edge).
//   DATA   : shift right, bit into [7] (LSB first); after 8th bit -> PARITY.
//   PARITY : store bit; -> STOP.
//   STOP   : data=1 and odd parity over 8 data + parity -> push byte; else
//            set PERR, no push. Always -> IDLE.
//   Timeout: in any non-IDLE state, counter reaching TIMEOUT_CYCLES with no fall
//            -> IDLE, partial byte discarded, no flag. Counter clears on every fall.
//  Push latency: byte visible in FIFO (irq high) 1 clk after the clk edge that
//   detects the stop-bit fall.
//  Register map (addr not matching either register -> data_out=8'h00):
//   DATA   : FIFO head, 8'h00 if empty. rd_en pops if non-empty; pop on empty: no-op.
//   STATUS : {4'b0, PERR, OVR, FULL, NE}. rd_en on STATUS clears OVR and PERR
//            (flag set in the same cycle as the clear wins: stays 1).
//  FIFO: count 0..2**FIFO_AW; pointers wrap mod depth.
//   Push when full with no same-cycle pop: byte dropped, OVR set, contents untouched.
//   Push and pop same cycle: both happen, count unchanged (also when full/empty
//   count=0 push+pop impossible since pop-on-empty is a no-op -> push only).
//  irq = NE, registered alongside FIFO count; no edge semantics.
//  reset_n assertion mid-frame or with FIFO occupied: everything returns to reset
//   values immediately (async); the next frame is received from its start bit.
// TESTING
//  1. Send frame 0x1C (start 0, 00111000 LSB-first, parity 0, stop 1) -> DATA=0x1C,
//     STATUS=0x01, irq=1 one clk after stop fall; rd_en on DATA -> STATUS=0x00, irq=0.
//  2. Send 9 bytes 0x01..0x09 without reads -> STATUS=0x07 (NE,FULL,OVR); reads
//     return 0x01..0x08 then 0x00; STATUS read clears OVR.
//  3. Frame 0x55 with parity bit 0 (even) -> no push, STATUS=0x08; next good frame
//     0xAA received normally; STATUS read -> PERR cleared.
//  4. Send start + 4 data bits, then idle TIMEOUT_CYCLES+1 clks, then full frame 0x5A
//     -> exactly one entry, DATA=0x5A, no flags.
//  5. FIFO full (8 entries); rd_en on DATA in the same clk as a push -> count stays 8,
//     OVR=0, order preserved across pointer wrap.
//  6. Pulse reset_n low mid-frame with 3 bytes queued -> STATUS=0x00, irq=0,
//     data_out=0 immediately; subsequent frame 0x12 received correctly.

Source files
------------

// File: rtl/ps2_kbd_in.sv
// PS/2 keyboard receiver: deserialises device-to-host frames into a byte FIFO
// and exposes DATA/STATUS registers with a level IRQ on the CPU bus.
module ps2_kbd_in #(
  parameter logic [15:0] BASE_ADDR      = 16'hFE10,
  parameter int unsigned FIFO_AW        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [15:0] addr,
  input  logic        rd_en,
  output logic [7:0]  data_out,
  output logic        irq
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] DATA_ADDR   = BASE_ADDR;
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic              kclk_s1_q, kclk_s1_d, kclk_s2_q, kclk_s2_d, kclk_prev_q, kclk_prev_d;
  logic              kdat_s1_q, kdat_s1_d, kdat_s2_q, kdat_s2_d;
  state_e            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovr_q, ovr_d, perr_q, perr_d, irq_q, irq_d;

  logic fall_c, push_c, perr_set_c;
  logic full_c, ne_c, data_sel_c, status_sel_c, pop_c, wr_c;

  // Two-flop synchronisers plus a delayed copy of the clock for fall detection
  always_comb begin
    kclk_s1_d   = ps2_clk;
    kclk_s2_d   = kclk_s1_q;
    kclk_prev_d = kclk_s2_q;
    kdat_s1_d   = ps2_data;
    kdat_s2_d   = kdat_s1_q;
    fall_c      = kclk_prev_q & ~kclk_s2_q;
  end

  // Frame FSM: advances on each PS/2 clock fall, aborts on inactivity
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    push_c     = 1'b0;
    perr_set_c = 1'b0;

    if (state_q == S_IDLE || fall_c) tmo_d = '0;
    else                             tmo_d = tmo_q + TW'(1);

    if (fall_c) begin
      case (state_q)
        S_IDLE: begin
          if (!kdat_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d = {kdat_s2_q, shift_q[7:1]};
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end
        S_PARITY: begin
          par_d   = kdat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (kdat_s2_q && (^{shift_q, par_q})) push_c = 1'b1;
          else                                  perr_set_c = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end
  end

  // FIFO, sticky flags and register side effects
  always_comb begin
    full_c       = (count_q == CW'(DEPTH));
    ne_c         = (count_q != '0);
    data_sel_c   = (addr == DATA_ADDR);
    status_sel_c = (addr == STATUS_ADDR);
    pop_c        = rd_en & data_sel_c & ne_c;
    wr_c         = push_c & (~full_c | pop_c);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    perr_d   = perr_q;

    if (wr_c) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);

    case ({wr_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A flag raised in the same cycle as the STATUS read must survive
    if (rd_en && status_sel_c) begin
      ovr_d  = 1'b0;
      perr_d = 1'b0;
    end
    if (push_c && full_c && !pop_c) ovr_d = 1'b1;
    if (perr_set_c)                 perr_d = 1'b1;

    irq_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kclk_s1_q   <= 1'b1;
      kclk_s2_q   <= 1'b1;
      kclk_prev_q <= 1'b1;
      kdat_s1_q   <= 1'b1;
      kdat_s2_q   <= 1'b1;
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovr_q       <= 1'b0;
      perr_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      kclk_s1_q   <= kclk_s1_d;
      kclk_s2_q   <= kclk_s2_d;
      kclk_prev_q <= kclk_prev_d;
      kdat_s1_q   <= kdat_s1_d;
      kdat_s2_q   <= kdat_s2_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovr_q       <= ovr_d;
      perr_q      <= perr_d;
      irq_q       <= irq_d;
    end
  end

  // Read mux is combinational from the bus address
  always_comb begin
    data_out = 8'h00;
    if (data_sel_c)        data_out = ne_c ? mem_q[rd_ptr_q] : 8'h00;
    else if (status_sel_c) data_out = {4'b0000, perr_q, ovr_q, full_c, ne_c};
  end

  assign irq = irq_q;

endmodule
